// File: rtl/pcie_cfg_pkg.sv
// -----------------------------------------------------------------------------
// pcie_cfg_pkg
//   Shared constants for the DMA-side PCIe completion path: the CplD header
//   format/type byte, the layout of the 73-bit word written into the
//   completion CDC FIFO, and the state type of the completion TLP builder.
//
//   FIFO word layout: {last, keep[7:0], data[63:0]}
//     keep = 8'hFF -> both DWs of data valid
//     keep = 8'h0F -> only the low DW (data[31:0]) valid
// -----------------------------------------------------------------------------
package pcie_cfg_pkg;

    localparam logic [7:0]  CPLD_FMT_TYPE  = 8'h4A;   // Fmt=3DW w/ data, Type=Cpl
    localparam int          PCIE_WORD_BITS = 73;
    localparam int          LAST_BIT       = 72;
    localparam int          KEEP_MSB       = 71;
    localparam int          KEEP_LSB       = 64;

    localparam logic [7:0]  KEEP_BOTH_DW   = 8'hFF;
    localparam logic [7:0]  KEEP_LOW_DW    = 8'h0F;
    localparam logic [10:0] MAX_LEN_DW     = 11'd1024; // encoded as len==0

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a completion descriptor
        ST_HDR1 = 2'd1,   // header DW0/DW1 loaded, next word carries DW2
        ST_DATA = 2'd2    // payload words, shifted by one DW
    } cpl_state_e;

    // Assemble one FIFO word from its fields.
    function automatic logic [PCIE_WORD_BITS-1:0] make_word(
        input logic        last,
        input logic [7:0]  keep,
        input logic [63:0] data
    );
        logic [PCIE_WORD_BITS-1:0] w;
        w                    = '0;
        w[LAST_BIT]          = last;
        w[KEEP_MSB:KEEP_LSB] = keep;
        w[KEEP_LSB-1:0]      = data;
        return w;
    endfunction

endpackage : pcie_cfg_pkg

// File: rtl/pcie_cpl_tlp_tx.sv
// -----------------------------------------------------------------------------
// pcie_cpl_tlp_tx
//   Builds PCIe Completion-with-Data TLPs on the DMA clock and streams them as
//   {last, keep, data} words into the completion CDC FIFO.
//
//   A TLP is the 3-DW header followed by the payload DWs. Because the header
//   is an odd number of DWs, every payload beat is split: its low DW finishes
//   the current output word and its high DW is held for the next one.
//
//   Ports
//     i_clk, i_rst          DMA clock, synchronous active-high reset
//     i_cpl_id              completer ID (static)
//     i_req_*               completion descriptor, valid/ready handshake
//     i_dat_* / o_dat_ready 64-bit payload beats, low DW first
//     o_wr, o_wdata         FIFO write strobe and 73-bit word
//     i_wfull               FIFO full (backpressure)
// -----------------------------------------------------------------------------
module pcie_cpl_tlp_tx
    import pcie_cfg_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [15:0]               i_cpl_id,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [9:0]                i_req_len,
    input  logic [11:0]               i_req_byte_cnt,
    input  logic [6:0]                i_req_lower_addr,
    input  logic [7:0]                i_req_tag,
    input  logic [15:0]               i_req_rid,
    input  logic                      i_dat_valid,
    output logic                      o_dat_ready,
    input  logic [63:0]               i_dat_data,
    output logic                      o_wr,
    output logic [PCIE_WORD_BITS-1:0] o_wdata,
    input  logic                      i_wfull
);

    cpl_state_e                state_q,   state_d;
    logic                      r_vld_q,   r_vld_d;
    logic [PCIE_WORD_BITS-1:0] r_wdata_q, r_wdata_d;
    logic [31:0]               hold_q,    hold_d;    // high DW of the last beat
    logic [10:0]               rem_q,     rem_d;     // payload DWs still to emit
    logic [10:0]               len_q,     len_d;     // L, with 0 expanded to 1024
    logic [31:0]               dw2_q,     dw2_d;

    logic        load_allowed;
    logic        req_fire;
    logic        dat_fire;
    logic [31:0] hdr_dw0;
    logic [31:0] hdr_dw1;
    logic [31:0] hdr_dw2;
    logic [10:0] len_eff;

    // The output register drains whenever the FIFO has room; a new word may be
    // loaded in the same cycle the old one is written, so a full-rate stream
    // never bubbles.
    assign o_wr         = r_vld_q & ~i_wfull;
    assign load_allowed = ~r_vld_q | o_wr;
    assign o_wdata      = r_wdata_q;

    assign o_req_ready = (state_q == ST_IDLE) & load_allowed;
    assign o_dat_ready = ((state_q == ST_HDR1) ||
                          ((state_q == ST_DATA) && (rem_q >= 11'd2))) & load_allowed;

    assign req_fire = i_req_valid & o_req_ready;
    assign dat_fire = i_dat_valid & o_dat_ready;

    assign hdr_dw0 = {CPLD_FMT_TYPE, 14'h0, i_req_len};
    assign hdr_dw1 = {i_cpl_id, 3'b000, 1'b0, i_req_byte_cnt};
    assign hdr_dw2 = {i_req_rid, i_req_tag, 1'b0, i_req_lower_addr};
    assign len_eff = (i_req_len == 10'd0) ? MAX_LEN_DW : {1'b0, i_req_len};

    always_comb begin
        // NOTE: every signal gets a default before the case so that paths
        // which do not assign it hold their value instead of inferring a latch.
        state_d   = state_q;
        r_vld_d   = r_vld_q & ~o_wr;
        r_wdata_d = r_wdata_q;
        hold_d    = hold_q;
        rem_d     = rem_q;
        len_d     = len_q;
        dw2_d     = dw2_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    r_vld_d   = 1'b1;
                    r_wdata_d = make_word(1'b0, KEEP_BOTH_DW, {hdr_dw1, hdr_dw0});
                    dw2_d     = hdr_dw2;
                    len_d     = len_eff;
                    state_d   = ST_HDR1;
                end
            end

            ST_HDR1: begin
                if (dat_fire) begin
                    r_vld_d   = 1'b1;
                    r_wdata_d = make_word(len_q == 11'd1, KEEP_BOTH_DW,
                                          {i_dat_data[31:0], dw2_q});
                    hold_d    = i_dat_data[63:32];
                    rem_d     = len_q - 11'd1;
                    state_d   = (len_q == 11'd1) ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (rem_q >= 11'd2) begin
                    if (dat_fire) begin
                        r_vld_d   = 1'b1;
                        r_wdata_d = make_word(rem_q == 11'd2, KEEP_BOTH_DW,
                                              {i_dat_data[31:0], hold_q});
                        hold_d    = i_dat_data[63:32];
                        rem_d     = rem_q - 11'd2;
                        state_d   = (rem_q == 11'd2) ? ST_IDLE : ST_DATA;
                    end
                end else if (load_allowed) begin
                    // One held DW left: flush it alone without taking a beat.
                    r_vld_d   = 1'b1;
                    r_wdata_d = make_word(1'b1, KEEP_LOW_DW, {32'h0, hold_q});
                    rem_d     = 11'd0;
                    state_d   = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // A reset mid-TLP abandons the partial TLP; words already in the FIFO stay
    // there, so the consumer side must be reset together with this block.
    always_ff @(posedge i_clk) begin
        // NOTE: state updates use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_rst) begin
            state_q   <= ST_IDLE;
            r_vld_q   <= 1'b0;
            r_wdata_q <= '0;
            hold_q    <= '0;
            rem_q     <= '0;
            len_q     <= '0;
            dw2_q     <= '0;
        end else begin
            state_q   <= state_d;
            r_vld_q   <= r_vld_d;
            r_wdata_q <= r_wdata_d;
            hold_q    <= hold_d;
            rem_q     <= rem_d;
            len_q     <= len_d;
            dw2_q     <= dw2_d;
        end
    end

endmodule : pcie_cpl_tlp_tx
